bus_drive_seq: RTL and testbench

- Parametrised output-enable sequencer for the VIC-II external address and data buses.
- Replaces the direct "drive when requested, else high-Z" muxing with a registered per-bus state machine.
- Inserts programmable turnaround (dead) cycles before driving and hold cycles after release, so the FPGA never fights the CPU or the bus transceiver.
- Sits between the vicii core (ado/dbo, write requests) and the top-level tri-state pad assignments, clocked by the dot4x clock.

---
 rtl/bus_drive_seq_if.sv | 29 ++
 rtl/bus_drive_seq.sv | 144 ++++++++++++++
 tb/tb_bus_drive_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_drive_seq_if.sv
// Core-to-pad bus bundle for the VIC-II address/data output-enable sequencer.
// The core side is the master; the sequencer itself is the slave.
interface bus_drive_seq_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
);
   logic                  ab_req;
   logic [ADDR_WIDTH-1:0] ab_in;
   logic                  db_req;
   logic [DATA_WIDTH-1:0] db_in;
   logic                  abort;
   logic                  ab_oe;
   logic [ADDR_WIDTH-1:0] ab_out;
   logic                  db_oe;
   logic [DATA_WIDTH-1:0] db_out;
   logic                  ls245_dir;
   logic                  ab_busy;
   logic                  db_busy;

   modport master (
      output ab_req, ab_in, db_req, db_in, abort,
      input  ab_oe, ab_out, db_oe, db_out, ls245_dir, ab_busy, db_busy
   );

   modport slave (
      input  ab_req, ab_in, db_req, db_in, abort,
      output ab_oe, ab_out, db_oe, db_out, ls245_dir, ab_busy, db_busy
   );
endinterface

// File: rtl/bus_drive_seq.sv
// Registered output-enable sequencer for the VIC-II address and data pads:
// turnaround cycles before driving, hold cycles after release, one FSM per bus.
module bus_drive_chan #(
   parameter int W           = 8,
   parameter int TURN_CYCLES = 1,
   parameter int HOLD_CYCLES = 1
) (
   input  logic         clk_dot4x,
   input  logic         rst_n,
   input  logic         abort_i,
   input  logic         req_i,
   input  logic [W-1:0] in_i,
   output logic         oe_o,
   output logic [W-1:0] out_o,
   output logic         busy_o
);
   typedef enum logic [1:0] {OFF, TURN, ON, HOLD} state_t;

   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES == 0 ? 0 : TURN_CYCLES - 1);
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES == 0 ? 0 : HOLD_CYCLES - 1);

   state_t       state_q;
   logic [3:0]   cnt_q;
   logic         oe_q;
   logic         busy_q;
   logic [W-1:0] out_q;

   // oe/busy are written alongside the state they decode, so they stay registered.
   // NOTE: every register here uses non-blocking assignment so all flops update
   // from the same pre-edge values regardless of statement order.
   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OFF;
         cnt_q   <= '0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         out_q   <= '0;
      end else if (abort_i) begin
         state_q <= OFF;
         cnt_q   <= '0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            OFF: if (req_i) begin
               busy_q <= 1'b1;
               if (TURN_CYCLES == 0) begin
                  state_q <= ON;
                  oe_q    <= 1'b1;
                  out_q   <= in_i;
               end else begin
                  state_q <= TURN;
                  cnt_q   <= TURN_LOAD;
               end
            end
            TURN: if (!req_i) begin
               state_q <= OFF;
               busy_q  <= 1'b0;
            end else if (cnt_q == 4'd0) begin
               state_q <= ON;
               oe_q    <= 1'b1;
               out_q   <= in_i;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            ON: if (!req_i) begin
               if (HOLD_CYCLES == 0) begin
                  state_q <= OFF;
                  oe_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= HOLD;
                  cnt_q   <= HOLD_LOAD;
               end
            end else begin
               out_q <= in_i;
            end
            // Same owner re-grabbing during hold needs no turnaround.
            HOLD: if (req_i) begin
               state_q <= ON;
               out_q   <= in_i;
            end else if (cnt_q == 4'd0) begin
               state_q <= OFF;
               oe_q    <= 1'b0;
               busy_q  <= 1'b0;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            default: begin
               state_q <= OFF;
               oe_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oe_o   = oe_q;
   assign out_o  = out_q;
   assign busy_o = busy_q;
endmodule

module bus_drive_seq #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8,
   parameter int TURN_CYCLES = 1,
   parameter int HOLD_CYCLES = 1
) (
   input logic           clk_dot4x,
   input logic           rst_n,
   bus_drive_seq_if.slave bus
);
   logic db_oe_w;

   bus_drive_chan #(
      .W(ADDR_WIDTH), .TURN_CYCLES(TURN_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
   ) u_ab (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .abort_i   (bus.abort),
      .req_i     (bus.ab_req),
      .in_i      (bus.ab_in),
      .oe_o      (bus.ab_oe),
      .out_o     (bus.ab_out),
      .busy_o    (bus.ab_busy)
   );

   bus_drive_chan #(
      .W(DATA_WIDTH), .TURN_CYCLES(TURN_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
   ) u_db (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .abort_i   (bus.abort),
      .req_i     (bus.db_req),
      .in_i      (bus.db_in),
      .oe_o      (db_oe_w),
      .out_o     (bus.db_out),
      .busy_o    (bus.db_busy)
   );

   // The transceiver points outward exactly while the data pads are driven.
   assign bus.db_oe     = db_oe_w;
   assign bus.ls245_dir = db_oe_w;
endmodule

// File: tb/tb_bus_drive_seq.sv
// Directed bench for bus_drive_seq: default (1/1), long-turnaround (2/1)
// and zero-parameter (0/0) instances driven from one clock.
module tb_bus_drive_seq;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   bus_drive_seq_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) if_a ();
   bus_drive_seq_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) if_b ();
   bus_drive_seq_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) if_z ();

   bus_drive_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TURN_CYCLES(1), .HOLD_CYCLES(1))
      dut_a (.clk_dot4x(clk), .rst_n(rst_n), .bus(if_a));
   bus_drive_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TURN_CYCLES(2), .HOLD_CYCLES(1))
      dut_b (.clk_dot4x(clk), .rst_n(rst_n), .bus(if_b));
   bus_drive_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TURN_CYCLES(0), .HOLD_CYCLES(0))
      dut_z (.clk_dot4x(clk), .rst_n(rst_n), .bus(if_z));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ab_req;
      logic [11:0] ab_in;
      logic        db_req;
      logic [7:0]  db_in;
      logic        abort;
      logic        e_ab_oe;
      logic [11:0] e_ab_out;
      logic        e_ab_busy;
      logic        e_db_oe;
      logic [7:0]  e_db_out;
      logic        e_db_busy;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Inputs applied after reset: a sequence through TURN/ON/HOLD, re-grab,
      // withdrawal and abort for the default 1/1 instance.
      vecs[0]  = '{1'b1, 12'h123, 1'b0, 8'h00, 1'b0, 1'b0, 12'h5A5, 1'b1, 1'b0, 8'hC3, 1'b0};
      vecs[1]  = '{1'b1, 12'h456, 1'b1, 8'h11, 1'b0, 1'b1, 12'h456, 1'b1, 1'b0, 8'hC3, 1'b1};
      vecs[2]  = '{1'b1, 12'h789, 1'b1, 8'h22, 1'b0, 1'b1, 12'h789, 1'b1, 1'b1, 8'h22, 1'b1};
      vecs[3]  = '{1'b0, 12'hAAA, 1'b1, 8'h33, 1'b0, 1'b1, 12'h789, 1'b1, 1'b1, 8'h33, 1'b1};
      vecs[4]  = '{1'b0, 12'hBBB, 1'b0, 8'h44, 1'b0, 1'b0, 12'h789, 1'b0, 1'b1, 8'h33, 1'b1};
      vecs[5]  = '{1'b1, 12'hCCC, 1'b1, 8'h55, 1'b0, 1'b0, 12'h789, 1'b1, 1'b1, 8'h55, 1'b1};
      vecs[6]  = '{1'b0, 12'hDDD, 1'b1, 8'h66, 1'b0, 1'b0, 12'h789, 1'b0, 1'b1, 8'h66, 1'b1};
      vecs[7]  = '{1'b1, 12'h111, 1'b1, 8'h77, 1'b1, 1'b0, 12'h789, 1'b0, 1'b0, 8'h66, 1'b0};
      vecs[8]  = '{1'b1, 12'h222, 1'b1, 8'h88, 1'b0, 1'b0, 12'h789, 1'b1, 1'b0, 8'h66, 1'b1};
      vecs[9]  = '{1'b1, 12'h333, 1'b1, 8'h99, 1'b0, 1'b1, 12'h333, 1'b1, 1'b1, 8'h99, 1'b1};
      vecs[10] = '{1'b1, 12'h444, 1'b1, 8'hAB, 1'b1, 1'b0, 12'h333, 1'b0, 1'b0, 8'h99, 1'b0};

      rst_n = 1'b0;
      if_a.ab_req = 1'b1; if_a.ab_in = 12'h5A5; if_a.db_req = 1'b1; if_a.db_in = 8'hC3; if_a.abort = 1'b0;
      if_b.ab_req = 1'b1; if_b.ab_in = 12'h5A5; if_b.db_req = 1'b1; if_b.db_in = 8'hC3; if_b.abort = 1'b0;
      if_z.ab_req = 1'b1; if_z.ab_in = 12'h5A5; if_z.db_req = 1'b1; if_z.db_in = 8'hC3; if_z.abort = 1'b0;

      // Reset held with requests active: everything stays at zero.
      tick(); tick();
      check("rst a.ab_oe",   32'(if_a.ab_oe), 0);
      check("rst a.ab_out",  32'(if_a.ab_out), 0);
      check("rst a.ab_busy", 32'(if_a.ab_busy), 0);
      check("rst a.db_oe",   32'(if_a.db_oe), 0);
      check("rst a.db_out",  32'(if_a.db_out), 0);
      check("rst a.db_busy", 32'(if_a.db_busy), 0);
      check("rst a.ls245",   32'(if_a.ls245_dir), 0);
      check("rst b.ab_oe",   32'(if_b.ab_oe), 0);
      check("rst z.ab_oe",   32'(if_z.ab_oe), 0);
      check("rst z.db_busy", 32'(if_z.db_busy), 0);

      // Release: default instance needs one dead cycle, zero-turn drives at once.
      rst_n = 1'b1;
      tick();
      check("rel1 a.ab_oe",   32'(if_a.ab_oe), 0);
      check("rel1 a.ab_busy", 32'(if_a.ab_busy), 1);
      check("rel1 a.db_oe",   32'(if_a.db_oe), 0);
      check("rel1 z.ab_oe",   32'(if_z.ab_oe), 1);
      check("rel1 z.ab_out",  32'(if_z.ab_out), 'h5A5);
      tick();
      check("rel2 a.ab_oe",  32'(if_a.ab_oe), 1);
      check("rel2 a.ab_out", 32'(if_a.ab_out), 'h5A5);
      check("rel2 a.db_oe",  32'(if_a.db_oe), 1);
      check("rel2 a.db_out", 32'(if_a.db_out), 'hC3);
      check("rel2 a.ls245",  32'(if_a.ls245_dir), 1);
      check("rel2 b.ab_oe",  32'(if_b.ab_oe), 0);

      // Abort all instances back to OFF.
      if_a.abort = 1'b1; if_b.abort = 1'b1; if_z.abort = 1'b1;
      tick();
      check("abort a.ab_oe",   32'(if_a.ab_oe), 0);
      check("abort a.db_busy", 32'(if_a.db_busy), 0);
      check("abort b.ab_busy", 32'(if_b.ab_busy), 0);
      check("abort z.db_oe",   32'(if_z.db_oe), 0);
      check("abort z.ab_out",  32'(if_z.ab_out), 'h5A5);
      if_a.abort = 1'b0; if_b.abort = 1'b0; if_z.abort = 1'b0;
      if_b.ab_req = 1'b0; if_b.db_req = 1'b0;
      if_z.ab_req = 1'b0; if_z.db_req = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if_a.ab_req = vecs[i].ab_req;
         if_a.ab_in  = vecs[i].ab_in;
         if_a.db_req = vecs[i].db_req;
         if_a.db_in  = vecs[i].db_in;
         if_a.abort  = vecs[i].abort;
         tick();
         check($sformatf("vec%0d ab_oe", i),   32'(if_a.ab_oe),     32'(vecs[i].e_ab_oe));
         check($sformatf("vec%0d ab_out", i),  32'(if_a.ab_out),    32'(vecs[i].e_ab_out));
         check($sformatf("vec%0d ab_busy", i), 32'(if_a.ab_busy),   32'(vecs[i].e_ab_busy));
         check($sformatf("vec%0d db_oe", i),   32'(if_a.db_oe),     32'(vecs[i].e_db_oe));
         check($sformatf("vec%0d db_out", i),  32'(if_a.db_out),    32'(vecs[i].e_db_out));
         check($sformatf("vec%0d db_busy", i), 32'(if_a.db_busy),   32'(vecs[i].e_db_busy));
         check($sformatf("vec%0d ls245", i),   32'(if_a.ls245_dir), 32'(vecs[i].e_db_oe));
      end
      if_a.abort = 1'b0; if_a.ab_req = 1'b0; if_a.db_req = 1'b0;

      // Two-cycle turnaround on the address bus.
      if_b.ab_req = 1'b1; if_b.ab_in = 12'hABC;
      tick();
      check("turn e0 b.ab_oe",   32'(if_b.ab_oe), 0);
      check("turn e0 b.ab_busy", 32'(if_b.ab_busy), 1);
      tick();
      check("turn e1 b.ab_oe", 32'(if_b.ab_oe), 0);
      tick();
      check("turn e2 b.ab_oe",  32'(if_b.ab_oe), 1);
      check("turn e2 b.ab_out", 32'(if_b.ab_out), 'hABC);
      if_b.ab_req = 1'b0; if_b.ab_in = 12'h000;
      tick();
      check("hold b.ab_oe",  32'(if_b.ab_oe), 1);
      check("hold b.ab_out", 32'(if_b.ab_out), 'hABC);
      tick();
      check("rel b.ab_oe",   32'(if_b.ab_oe), 0);
      check("rel b.ab_busy", 32'(if_b.ab_busy), 0);

      // One-cycle request pulse is withdrawn during turnaround.
      if_b.ab_req = 1'b1; if_b.ab_in = 12'h777;
      tick();
      check("pulse b.ab_busy", 32'(if_b.ab_busy), 1);
      if_b.ab_req = 1'b0;
      tick();
      check("wd b.ab_oe",   32'(if_b.ab_oe), 0);
      check("wd b.ab_busy", 32'(if_b.ab_busy), 0);
      tick();
      check("wd2 b.ab_oe",  32'(if_b.ab_oe), 0);
      check("wd2 b.ab_out", 32'(if_b.ab_out), 'hABC);

      // Data hold: value frozen for one cycle after the request drops.
      if_b.db_req = 1'b1; if_b.db_in = 8'h5A;
      tick(); tick(); tick();
      check("dh on b.db_oe",  32'(if_b.db_oe), 1);
      check("dh on b.db_out", 32'(if_b.db_out), 'h5A);
      if_b.db_req = 1'b0; if_b.db_in = 8'hFF;
      tick();
      check("dh hold b.db_oe",  32'(if_b.db_oe), 1);
      check("dh hold b.db_out", 32'(if_b.db_out), 'h5A);
      check("dh hold b.ls245",  32'(if_b.ls245_dir), 1);
      tick();
      check("dh off b.db_oe",   32'(if_b.db_oe), 0);
      check("dh off b.ls245",   32'(if_b.ls245_dir), 0);
      check("dh off b.db_busy", 32'(if_b.db_busy), 0);

      // Re-grab during hold: no dead cycle, output resumes tracking.
      if_b.db_req = 1'b1; if_b.db_in = 8'h5A;
      tick(); tick(); tick();
      if_b.db_req = 1'b0; if_b.db_in = 8'h77;
      tick();
      check("rg hold b.db_oe",  32'(if_b.db_oe), 1);
      check("rg hold b.db_out", 32'(if_b.db_out), 'h5A);
      if_b.db_req = 1'b1; if_b.db_in = 8'h88;
      tick();
      check("rg on b.db_oe",  32'(if_b.db_oe), 1);
      check("rg on b.db_out", 32'(if_b.db_out), 'h88);
      if_b.db_in = 8'h99;
      tick();
      check("rg trk b.db_out", 32'(if_b.db_out), 'h99);
      if_b.db_req = 1'b0;

      // Zero turnaround and zero hold.
      if_z.ab_req = 1'b1; if_z.ab_in = 12'h111;
      if_z.db_req = 1'b1; if_z.db_in = 8'hA1;
      tick();
      check("z on ab_oe",  32'(if_z.ab_oe), 1);
      check("z on ab_out", 32'(if_z.ab_out), 'h111);
      check("z on ls245",  32'(if_z.ls245_dir), 1);
      check("z on db_out", 32'(if_z.db_out), 'hA1);
      if_z.ab_in = 12'h222; if_z.db_req = 1'b0;
      tick();
      check("z trk ab_out", 32'(if_z.ab_out), 'h222);
      check("z off db_oe",  32'(if_z.db_oe), 0);
      check("z off ls245",  32'(if_z.ls245_dir), 0);
      if_z.ab_req = 1'b0; if_z.ab_in = 12'h333;
      tick();
      check("z off ab_oe",   32'(if_z.ab_oe), 0);
      check("z off ab_busy", 32'(if_z.ab_busy), 0);
      check("z off ab_out",  32'(if_z.ab_out), 'h222);

      // Asynchronous reset in the middle of driving drops oe immediately.
      if_a.ab_req = 1'b1; if_a.ab_in = 12'h3C3;
      tick(); tick();
      check("mid a.ab_oe", 32'(if_a.ab_oe), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst a.ab_oe",  32'(if_a.ab_oe), 0);
      check("mid rst a.ab_out", 32'(if_a.ab_out), 0);
      check("mid rst b.db_out", 32'(if_b.db_out), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
